// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding for the serial arithmetic
// blocks and the widest operand any of them supports.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first: {cout,sum} = a + b + cin after WIDTH RUN cycles
// plus one DONE cycle; start is ignored while busy, accepted in IDLE or DONE.
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_sum;
  logic [CNT_W-1:0] count;
  logic             carry;
  logic             fa_sum;
  logic             fa_carry;
  logic             accept;
  logic             last_bit;

  full_adder u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // The final sum bit lands in the MSB on the same edge that publishes the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a   <= '0;
      sh_b   <= '0;
      sh_sum <= '0;
      count  <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      sh_a   <= a;
      sh_b   <= b;
      sh_sum <= '0;
      count  <= '0;
      carry  <= cin;
    end else if (state == RUN) begin
      sh_a   <= sh_a >> 1;
      sh_b   <= sh_b >> 1;
      sh_sum <= {fa_sum, sh_sum[WIDTH-1:1]};
      carry  <= fa_carry;
      count  <= count + CNT_W'(1);
      if (last_bit) begin
        sum  <= {fa_sum, sh_sum[WIDTH-1:1]};
        cout <= fa_carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=32 side by side.
module tb_serial_adder;

  typedef struct {
    logic [64:0] res;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        start_s [2];
  logic [63:0] a_s     [2];
  logic [63:0] b_s     [2];
  logic        cin_s   [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        cout_s  [2];
  logic [63:0] sum_s   [2];

  logic [7:0]  sum8;
  logic [31:0] sum32;
  logic        busy8, done8, cout8, busy32, done32, cout32;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start_s[0]), .a(a_s[0][7:0]), .b(b_s[0][7:0]),
    .cin(cin_s[0]), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start_s[1]), .a(a_s[1][31:0]), .b(b_s[1][31:0]),
    .cin(cin_s[1]), .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
  );

  assign sum_s[0]  = 64'(sum8);
  assign sum_s[1]  = 64'(sum32);
  assign busy_s[0] = busy8;
  assign busy_s[1] = busy32;
  assign done_s[0] = done8;
  assign done_s[1] = done32;
  assign cout_s[0] = cout8;
  assign cout_s[1] = cout32;

  int          wid [2] = '{8, 32};
  exp_t        q   [2][$];
  logic [64:0] last[2];
  int          ok  [2];
  int          acc [2];
  bit          armed = 1'b0;
  int          compared = 0;
  int          mismatched = 0;

  task automatic chk(input string nm, input int g, input logic [64:0] act, input logic [64:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s width=%0d cyc=%0d actual=%h required=%h", nm, wid[g], cyc, act, exp);
    end
  endtask

  // Reference model: an operation accepted at edge e is busy for edges e..e+W-1,
  // shows done after edge e+W, and the next start can be taken at edge e+W+1.
  task automatic step();
    exp_t        e;
    logic [64:0] m;
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      m = (65'd1 << wid[g]) - 65'd1;
      if (rst) begin
        q[g].delete();
        last[g] = '0;
        ok[g]   = cyc;
      end else if (start_s[g] && cyc >= ok[g]) begin
        e.res = (65'(a_s[g]) & m) + (65'(b_s[g]) & m) + 65'(cin_s[g]);
        e.t   = cyc + wid[g];
        q[g].push_back(e);
        ok[g] = cyc + wid[g] + 1;
        acc[g]++;
      end
    end
    if (rst) armed = 1'b1;
  endtask

  always @(negedge clk) begin
    logic        eb, ed;
    logic [64:0] act;
    if (armed) begin
      for (int g = 0; g < 2; g++) begin
        eb = (q[g].size() > 0) && (cyc < q[g][0].t);
        ed = (q[g].size() > 0) && (cyc == q[g][0].t);
        chk("busy", g, 65'(busy_s[g]), 65'(eb));
        chk("done", g, 65'(done_s[g]), 65'(ed));
        if (ed) begin
          last[g] = q[g][0].res;
          void'(q[g].pop_front());
        end
        act = 65'(sum_s[g]) | (65'(cout_s[g]) << wid[g]);
        chk("result", g, act, last[g]);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    start_s[0] = 1'b1;
    a_s[0]     = 64'(a);
    b_s[0]     = 64'(b);
    cin_s[0]   = c;
    step();
    start_s[0] = 1'b0;
  endtask

  task automatic wait_acc(input int g);
    int n;
    int k;
    n = acc[g];
    k = 0;
    while (acc[g] == n && k < 100) begin
      step();
      k++;
    end
    chk("accept_timeout", g, 65'(acc[g] != n), 65'd1);
  endtask

  initial begin
    int n0, n1, k;
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0;
      a_s[g]     = '0;
      b_s[g]     = '0;
      cin_s[g]   = 1'b0;
      last[g]    = '0;
      ok[g]      = 0;
      acc[g]     = 0;
    end
    rst = 1'b1;
    idle(2);
    rst = 1'b0;

    op8(8'h00, 8'h00, 1'b0);
    idle(12);
    op8(8'hFF, 8'h01, 1'b0);
    idle(10);
    op8(8'hA5, 8'h5A, 1'b1);
    idle(10);
    op8(8'h3C, 8'h42, 1'b0);
    idle(10);

    // Start during RUN must be ignored.
    op8(8'h10, 8'h20, 1'b0);
    idle(2);
    start_s[0] = 1'b1;
    a_s[0]     = 64'hFF;
    b_s[0]     = 64'hFF;
    step();
    start_s[0] = 1'b0;
    idle(12);

    // Reset in the fourth RUN cycle drops the operation.
    op8(8'hFF, 8'hFF, 1'b1);
    idle(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(12);
    op8(8'h12, 8'h34, 1'b1);
    idle(10);

    // Held start: back-to-back operations.
    start_s[0] = 1'b1;
    a_s[0]     = 64'h01;
    b_s[0]     = 64'h01;
    cin_s[0]   = 1'b0;
    wait_acc(0);
    a_s[0] = 64'h80;
    b_s[0] = 64'h80;
    wait_acc(0);
    start_s[0] = 1'b0;
    idle(12);

    // Random regression; operands change every cycle, including mid-RUN.
    n0 = acc[0];
    n1 = acc[1];
    k  = 0;
    while ((acc[0] < n0 + 1000 || acc[1] < n1 + 1000) && k < 60000) begin
      for (int g = 0; g < 2; g++) begin
        start_s[g] = ($urandom_range(0, 7) != 0);
        a_s[g]     = {$urandom, $urandom};
        b_s[g]     = {$urandom, $urandom};
        cin_s[g]   = 1'($urandom_range(0, 1));
      end
      step();
      k++;
    end
    chk("random_timeout", 0, 65'(acc[0] >= n0 + 1000), 65'd1);
    chk("random_timeout", 1, 65'(acc[1] >= n1 + 1000), 65'd1);
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    idle(40);
    chk("drain", 0, 65'(q[0].size()), 65'd0);
    chk("drain", 1, 65'(q[1].size()), 65'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
